// File: rtl/adventure_grid_fsm.sv
`default_nettype none
// ============================================================================
// Module   : adventure_grid_fsm
// Brief    : ROWS x COLS room-grid adventure game with sword, dragon and move budget.
// Revision : 1.0 - initial release
// ============================================================================
module adventure_grid_fsm #(
    parameter int                 ROWS        = 3,
    parameter int                 COLS        = 3,
    parameter int                 START       = 0,
    parameter int                 SWORD_ROOM  = 6,
    parameter int                 DRAGON_ROOM = 8,
    parameter logic [ROWS*COLS-1:0] WALL_E    = '0,
    parameter logic [ROWS*COLS-1:0] WALL_S    = '0,
    parameter int                 MOVE_LIMIT  = 16,
    localparam int                c_n         = ROWS * COLS,
    localparam int                c_room_w    = (c_n > 1) ? $clog2(c_n) : 1,
    localparam int                c_move_w    = (MOVE_LIMIT > 0) ? $clog2(MOVE_LIMIT + 1) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                n,
    input  logic                s,
    input  logic                e,
    input  logic                w,
    input  logic                v,
    output logic [c_room_w-1:0] room,
    output logic [c_n-1:0]      room_oh,
    output logic                sw,
    output logic                win,
    output logic                d,
    output logic [c_move_w-1:0] moves,
    output logic                bump
);

    localparam logic [1:0] c_explore = 2'd0;
    localparam logic [1:0] c_dragon  = 2'd1;
    localparam logic [1:0] c_win     = 2'd2;
    localparam logic [1:0] c_dead    = 2'd3;

    localparam logic [c_room_w-1:0] c_start     = c_room_w'(START);
    localparam logic [c_room_w-1:0] c_sword     = c_room_w'(SWORD_ROOM);
    localparam logic [c_room_w-1:0] c_dragon_rm = c_room_w'(DRAGON_ROOM);
    localparam logic [c_room_w-1:0] c_row_step  = c_room_w'(COLS);
    localparam logic [c_move_w-1:0] c_limit     = c_move_w'(MOVE_LIMIT);
    localparam bit                  c_timeout_en = (MOVE_LIMIT > 0);

    if (ROWS < 1 || COLS < 1 || START >= c_n || SWORD_ROOM >= c_n || DRAGON_ROOM >= c_n ||
        START < 0 || SWORD_ROOM < 0 || DRAGON_ROOM < 0 ||
        START == SWORD_ROOM || START == DRAGON_ROOM || SWORD_ROOM == DRAGON_ROOM) begin : g_cfg_error
        $error("adventure_grid_fsm: START/SWORD_ROOM/DRAGON_ROOM must be distinct and below ROWS*COLS");
    end

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_room_w-1:0] r_room;
    logic [c_room_w-1:0] w_room_next;
    logic [c_n-1:0]      r_room_oh;
    logic                r_sw;
    logic                w_sw_next;
    logic                r_win;
    logic                w_win_next;
    logic                r_d;
    logic                w_d_next;
    logic [c_move_w-1:0] r_moves;
    logic [c_move_w-1:0] w_moves_next;
    logic [c_move_w-1:0] w_moves_inc;
    logic                r_bump;
    logic                w_bump_next;

    logic [c_n-1:0]      w_blk_n;
    logic [c_n-1:0]      w_blk_s;
    logic [c_n-1:0]      w_blk_e;
    logic [c_n-1:0]      w_blk_w;
    logic                w_dir_one;
    logic                w_blocked;
    logic [c_room_w-1:0] w_target;
    logic                w_move_open;
    logic                w_hit_dragon;
    logic                w_timeout;

    // Per-room blocked flags fold grid edges and wall masks into constants.
    for (genvar i = 0; i < c_n; i++) begin : g_room
        if (i < COLS) begin : g_n_edge
            assign w_blk_n[i] = 1'b1;
        end else begin : g_n_wall
            assign w_blk_n[i] = WALL_S[i-COLS];
        end
        if (i >= c_n - COLS) begin : g_s_edge
            assign w_blk_s[i] = 1'b1;
        end else begin : g_s_wall
            assign w_blk_s[i] = WALL_S[i];
        end
        if ((i % COLS) == 0) begin : g_w_edge
            assign w_blk_w[i] = 1'b1;
        end else begin : g_w_wall
            assign w_blk_w[i] = WALL_E[i-1];
        end
        if ((i % COLS) == COLS - 1) begin : g_e_edge
            assign w_blk_e[i] = 1'b1;
        end else begin : g_e_wall
            assign w_blk_e[i] = WALL_E[i];
        end
    end

    always_comb begin
        w_blocked = 1'b0;
        w_target  = r_room;
        if (n) begin
            w_blocked = w_blk_n[r_room];
            w_target  = r_room - c_row_step;
        end else if (s) begin
            w_blocked = w_blk_s[r_room];
            w_target  = r_room + c_row_step;
        end else if (e) begin
            w_blocked = w_blk_e[r_room];
            w_target  = r_room + 1'b1;
        end else if (w) begin
            w_blocked = w_blk_w[r_room];
            w_target  = r_room - 1'b1;
        end
    end

    assign w_dir_one    = $onehot({n, s, e, w});
    assign w_move_open  = (r_state == c_explore) && w_dir_one && !w_blocked;
    assign w_hit_dragon = (w_target == c_dragon_rm);
    assign w_moves_inc  = (r_moves == {c_move_w{1'b1}}) ? r_moves : r_moves + 1'b1;
    assign w_timeout    = c_timeout_en && (w_moves_inc == c_limit);

    // State and all output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_explore;
            r_room    <= c_start;
            r_room_oh <= c_n'(1) << START;
            r_sw      <= 1'b0;
            r_win     <= 1'b0;
            r_d       <= 1'b0;
            r_moves   <= '0;
            r_bump    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_room    <= w_room_next;
            r_room_oh <= c_n'(1) << w_room_next;
            r_sw      <= w_sw_next;
            r_win     <= w_win_next;
            r_d       <= w_d_next;
            r_moves   <= w_moves_next;
            r_bump    <= w_bump_next;
        end
    end

    // Dragon entry outranks the timeout on the same move.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_explore: begin
                if (w_move_open) begin
                    if (w_hit_dragon)   w_state_next = c_dragon;
                    else if (w_timeout) w_state_next = c_dead;
                end
            end
            c_dragon: w_state_next = (r_sw && v) ? c_win : c_dead;
            default:  w_state_next = r_state;
        endcase
    end

    always_comb begin
        w_room_next  = r_room;
        w_moves_next = r_moves;
        w_sw_next    = r_sw;
        w_win_next   = r_win;
        w_d_next     = r_d;
        w_bump_next  = 1'b0;
        case (r_state)
            c_explore: begin
                if (w_dir_one) begin
                    if (w_blocked) begin
                        w_bump_next = 1'b1;
                    end else begin
                        w_room_next  = w_target;
                        w_moves_next = w_moves_inc;
                        if (w_target == c_sword)         w_sw_next = 1'b1;
                        if (!w_hit_dragon && w_timeout) w_d_next  = 1'b1;
                    end
                end
            end
            c_dragon: begin
                if (r_sw && v) w_win_next = 1'b1;
                else           w_d_next   = 1'b1;
            end
            default: ;
        endcase
    end

    assign room    = r_room;
    assign room_oh = r_room_oh;
    assign sw      = r_sw;
    assign win     = r_win;
    assign d       = r_d;
    assign moves   = r_moves;
    assign bump    = r_bump;

endmodule
`default_nettype wire

// File: tb/tb_adventure_grid_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_adventure_grid_fsm
// Brief    : Directed self-checking bench; default map plus a walled variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adventure_grid_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0, v = 1'b0;

    logic [3:0] room_a, room_b;
    logic [8:0] room_oh_a, room_oh_b;
    logic       sw_a, win_a, d_a, bump_a;
    logic       sw_b, win_b, d_b, bump_b;
    logic [4:0] moves_a, moves_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adventure_grid_fsm dut_a (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w), .v(v),
        .room(room_a), .room_oh(room_oh_a), .sw(sw_a), .win(win_a), .d(d_a),
        .moves(moves_a), .bump(bump_a)
    );

    adventure_grid_fsm #(.WALL_E(9'b000000001)) dut_b (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w), .v(v),
        .room(room_b), .room_oh(room_oh_b), .sw(sw_b), .win(win_b), .d(d_b),
        .moves(moves_b), .bump(bump_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one input vector across one rising edge, then sample 1 ns later.
    task automatic step(input logic pn, input logic ps, input logic pe, input logic pw, input logic pv);
        n = pn; s = ps; e = pe; w = pw; v = pv;
        @(posedge clk);
        #1;
        n = 1'b0; s = 1'b0; e = 1'b0; w = 1'b0; v = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_room"},    32'(room_a),    32'd0);
        check({tag, "_room_oh"}, 32'(room_oh_a), 32'h001);
        check({tag, "_sw"},      32'(sw_a),      32'd0);
        check({tag, "_win"},     32'(win_a),     32'd0);
        check({tag, "_d"},       32'(d_a),       32'd0);
        check({tag, "_moves"},   32'(moves_a),   32'd0);
        check({tag, "_bump"},    32'(bump_a),    32'd0);
    endtask

    initial begin
        // Sword path then victory
        do_reset();
        check_reset_state("rst");
        step(0, 1, 0, 0, 0); check("t1_room3", 32'(room_a), 32'd3);
        step(0, 1, 0, 0, 0); check("t1_room6", 32'(room_a), 32'd6);
        check("t1_sw", 32'(sw_a), 32'd1);
        step(0, 0, 1, 0, 0); check("t1_room7", 32'(room_a), 32'd7);
        step(0, 0, 1, 0, 0); check("t1_room8", 32'(room_a), 32'd8);
        check("t1_dragon_nowin", 32'(win_a), 32'd0);
        check("t1_dragon_nod",   32'(d_a),   32'd0);
        step(0, 0, 0, 0, 1);
        check("t1_win",   32'(win_a),     32'd1);
        check("t1_d",     32'(d_a),       32'd0);
        check("t1_moves", 32'(moves_a),   32'd4);
        check("t1_oh",    32'(room_oh_a), 32'h100);

        // No sword: death at the dragon
        do_reset();
        step(0, 0, 1, 0, 0); check("t2_room1", 32'(room_a), 32'd1);
        step(0, 0, 1, 0, 0); check("t2_room2", 32'(room_a), 32'd2);
        step(0, 1, 0, 0, 0); check("t2_room5", 32'(room_a), 32'd5);
        step(0, 1, 0, 0, 0); check("t2_room8", 32'(room_a), 32'd8);
        step(0, 0, 0, 0, 1);
        check("t2_d",   32'(d_a),   32'd1);
        check("t2_win", 32'(win_a), 32'd0);
        check("t2_sw",  32'(sw_a),  32'd0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("t2_frozen_room",  32'(room_a),  32'd8);
        check("t2_frozen_moves", 32'(moves_a), 32'd4);
        check("t2_frozen_bump",  32'(bump_a),  32'd0);

        // Edge bumps and multi-direction input
        do_reset();
        step(1, 0, 0, 0, 0);
        check("t3_bump_n", 32'(bump_a), 32'd1);
        check("t3_room_n", 32'(room_a), 32'd0);
        step(0, 0, 0, 1, 0);
        check("t3_bump_w",  32'(bump_a),  32'd1);
        check("t3_room_w",  32'(room_a),  32'd0);
        check("t3_moves_w", 32'(moves_a), 32'd0);
        step(1, 0, 1, 0, 0);
        check("t3_multi_bump",  32'(bump_a),  32'd0);
        check("t3_multi_room",  32'(room_a),  32'd0);
        check("t3_multi_moves", 32'(moves_a), 32'd0);

        // Walled map (dut_b): wall between rooms 0 and 1
        do_reset();
        step(0, 0, 1, 0, 0);
        check("t4_wall_bump", 32'(bump_b), 32'd1);
        check("t4_wall_room", 32'(room_b), 32'd0);
        step(0, 1, 0, 0, 0); check("t4_room3", 32'(room_b), 32'd3);
        check("t4_bump_clr", 32'(bump_b), 32'd0);
        step(0, 0, 1, 0, 0); check("t4_room4", 32'(room_b), 32'd4);
        step(1, 0, 0, 0, 0); check("t4_room1", 32'(room_b), 32'd1);
        step(0, 0, 0, 1, 0);
        check("t4_wall_w_bump", 32'(bump_b), 32'd1);
        check("t4_wall_w_room", 32'(room_b), 32'd1);
        check("t4_moves",       32'(moves_b), 32'd3);

        // Move budget exhaustion
        do_reset();
        for (int i = 0; i < 15; i++) begin
            if (i % 2 == 0) step(0, 0, 1, 0, 0);
            else            step(0, 0, 0, 1, 0);
        end
        check("t5_alive15", 32'(d_a),     32'd0);
        check("t5_moves15", 32'(moves_a), 32'd15);
        step(0, 0, 0, 1, 0);
        check("t5_dead",  32'(d_a),     32'd1);
        check("t5_moves", 32'(moves_a), 32'd16);
        check("t5_room",  32'(room_a),  32'd0);
        check("t5_win",   32'(win_a),   32'd0);
        step(0, 0, 1, 0, 0);
        check("t5_after_room",  32'(room_a),  32'd0);
        check("t5_after_moves", 32'(moves_a), 32'd16);

        // Reset while in DRAGON, then while in WIN
        do_reset();
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0);
        check("t6_at_dragon", 32'(room_a), 32'd8);
        reset = 1'b1;
        step(0, 0, 0, 0, 1);
        reset = 1'b0;
        check_reset_state("t6_dragon_rst");
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        check("t6_won", 32'(win_a), 32'd1);
        do_reset();
        check_reset_state("t6_win_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
